ip_mem: RTL and testbench
=========================

Name: ip_mem

Overview:
- Input-peripheral memory region of the LSU: the read-side counterpart of the output peripheral memory that drives LEDs, HEX and LCD.
- Synchronizes the board switches and push-buttons into the clock domain and debounces the buttons.
- Latches button-press events in a sticky edge-capture register.
- Returns the selected register on the LSU read-data path.
- Write access is limited to clearing edge-capture bits (write-1-to-clear).

Parameters:
- SW_W, 18: number of slide switches.
- BTN_W, 4: number of push-buttons.
- DEBOUNCE_CYCLES, 65536: consecutive stable cycles required before a button change is accepted; legal range is 2 or more.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_lsu_wren  input  1  LSU write enable; only the edge-capture address accepts writes.
- i_ip_addr  input  16  LSU byte address; bits [1:0] are ignored (word decode).
- i_ip_data  input  32  LSU write data.
- i_io_sw  input  SW_W  raw slide switches, asynchronous.
- i_io_btn  input  BTN_W  raw push-buttons, asynchronous, active-low (0 = pressed).
- o_ip_data  output  32  read data for the decoded address.

Behaviour:
- Address map, decoded on i_ip_addr[15:2]:
  - 0x7800 SW: {zero-extend, sw_sync}.
  - 0x7810 BTN: {zero-extend, btn_db}, where 1 = pressed.
  - 0x7814 EDGE: {zero-extend, edge_cap}.
  - Any other address reads 32'h0.
- o_ip_data is combinational from the registered state and address. Same-cycle read has no wait states.
- Reset (i_rst=0, asynchronous):
  - Switch synchronizer stages = 0.
  - Button synchronizer stages = all 1 (released).
  - btn_db = 0, all debounce counters = 0, edge_cap = 0.
  - o_ip_data therefore reads 0 for every address while reset is held.
- Synchronizers: two flops per bit. A raw change becomes visible in sw_sync / btn_sync after the 2nd rising edge.
- Debounce, per button i, with s = ~btn_sync[i] (1 = pressed) and d = btn_db[i]:
  - If s == d: cnt[i] <= 0.
  - If s != d and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - If s != d and cnt[i] == DEBOUNCE_CYCLES-1: d <= s and cnt[i] <= 0.
  - Net effect: d changes on the DEBOUNCE_CYCLES-th consecutive mismatched edge.
  - Any glitch back to s == d restarts the count from 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it never wraps.
- Edge capture: edge_cap[i] is set on the same edge where d goes 0->1. Releases (1->0) never set it.
- Write-1-to-clear:
  - Condition: i_lsu_wren=1 and address decodes to 0x7814.
  - Effect: edge_cap <= edge_cap & ~i_ip_data[BTN_W-1:0].
  - If a set and a clear of the same bit coincide, the set wins (bit reads 1 afterwards).
  - Writes to 0x7800, 0x7810 or unmapped addresses are ignored and change no state.
- Total press latency, raw edge to BTN/EDGE bit = 1: 2 + DEBOUNCE_CYCLES rising edges, with the raw level held stable.
- Reset asserted mid-debounce:
  - Pending counts are discarded and btn_db returns to 0.
  - A button still held after reset release is re-qualified as a fresh press, setting its edge bit after the full latency.
- Buttons are independent; simultaneous presses each set their own bit on their own qualifying edge.

Test Plan:
- Reset and idle (DEBOUNCE_CYCLES=4): hold i_rst=0 with i_io_sw=18'h3FFFF and i_io_btn=4'h0 (all pressed) -> reads of 0x7800, 0x7810 and 0x7814 all return 0. Release reset, all buttons pressed -> 0x7810 and 0x7814 read 32'hF after 6 edges.
- Switches: set i_io_sw=18'h2A5A5 -> 0x7800 reads 32'h0002A5A5 after the 2nd edge and the previous value after the 1st. Reading 0x7804 returns 32'h0.
- Debounce glitch: with btn[0], toggle low for 3 cycles, high for 1, then low for 3 cycles -> BTN stays 0. Hold low for 6 edges -> BTN reads 32'h1 exactly at edge 6 and EDGE reads 32'h1.
- Release and W1C: release btn[0] for 6+ cycles -> BTN reads 0 and EDGE stays 32'h1. Write 32'h1 to 0x7814 -> EDGE reads 0. Write 32'hF to 0x7810 -> no state change.
- Set/clear collision: time a W1C of bit 2 to land on the same edge btn[2] qualifies -> EDGE bit 2 reads 1. A W1C of bit 3 with btn[3] idle leaves bit 3 at 0.
- Reset mid-debounce: btn[1] held pressed for 3 edges, pulse i_rst low for half a cycle, keep the button held -> BTN/EDGE bit 1 reads 0 until 6 edges after reset release, then reads 1.

Source files
------------

// File: rtl/ip_mem.sv
// Input-peripheral region of the LSU: switch/button sync, button debounce,
// sticky press capture with write-1-to-clear, and word-decoded read-back.
module ip_mem #(
  parameter int SW_W            = 18,
  parameter int BTN_W           = 4,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_lsu_wren,
  input  logic [15:0]      i_ip_addr,
  input  logic [31:0]      i_ip_data,
  input  logic [SW_W-1:0]  i_io_sw,
  input  logic [BTN_W-1:0] i_io_btn,
  output logic [31:0]      o_ip_data
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [13:0] A_SW   = 14'h1E00;
  localparam logic [13:0] A_BTN  = 14'h1E04;
  localparam logic [13:0] A_EDGE = 14'h1E05;

  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [BTN_W-1:0] btn_s1_q, btn_s2_q;
  logic [BTN_W-1:0] db_q, db_d;
  logic [BTN_W-1:0] edge_q, edge_d;
  logic [CW-1:0]    cnt_q [BTN_W];
  logic [CW-1:0]    cnt_d [BTN_W];

  logic             sel_sw, sel_btn, sel_edge;
  logic [BTN_W-1:0] press, clr;
  logic             unused_ok;

  assign sel_sw   = (i_ip_addr[15:2] == A_SW);
  assign sel_btn  = (i_ip_addr[15:2] == A_BTN);
  assign sel_edge = (i_ip_addr[15:2] == A_EDGE);

  assign unused_ok = ^{i_ip_addr[1:0], i_ip_data[31:BTN_W]};

  // buttons are active-low on the board; internally 1 = pressed
  assign press = ~btn_s2_q;

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < BTN_W; i++) begin
      cnt_d[i] = '0;
      if (press[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) db_d[i] = press[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign clr = (i_lsu_wren && sel_edge) ?
               i_ip_data[BTN_W-1:0] : '0;

  // a new press wins over a same-cycle clear
  assign edge_d = (edge_q & ~clr) | (db_d & ~db_q);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '1;
      btn_s2_q <= '1;
      db_q     <= '0;
      edge_q   <= '0;
      for (int i = 0; i < BTN_W; i++) cnt_q[i] <= '0;
    end else begin
      sw_s1_q  <= i_io_sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= i_io_btn;
      btn_s2_q <= btn_s1_q;
      db_q     <= db_d;
      edge_q   <= edge_d;
      for (int i = 0; i < BTN_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    o_ip_data = '0;
    unique case (1'b1)
      sel_sw:   o_ip_data = 32'(sw_s2_q);
      sel_btn:  o_ip_data = 32'(db_q);
      sel_edge: o_ip_data = 32'(edge_q);
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_ip_mem.sv
// Bench for ip_mem with DEBOUNCE_CYCLES=4 (press latency of 6 edges).
// Expected reads are queued, then drained against the read port.
module tb_ip_mem;

  localparam int SW_W  = 18;
  localparam int BTN_W = 4;
  localparam int DB    = 4;

  localparam logic [15:0] A_SW   = 16'h7800;
  localparam logic [15:0] A_SWX  = 16'h7804;
  localparam logic [15:0] A_BTN  = 16'h7810;
  localparam logic [15:0] A_EDGE = 16'h7814;

  logic             clk;
  logic             rst_n;
  logic             wren;
  logic [15:0]      addr;
  logic [31:0]      wdata;
  logic [SW_W-1:0]  sw;
  logic [BTN_W-1:0] btn;
  logic [31:0]      rdata;

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  ip_mem #(
    .SW_W(SW_W),
    .BTN_W(BTN_W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_lsu_wren(wren),
    .i_ip_addr(addr),
    .i_ip_data(wdata),
    .i_io_sw(sw),
    .i_io_btn(btn),
    .o_ip_data(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic expect_rd(input string tag,
                           input logic [15:0] a,
                           input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.a   = a;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      addr = e.a;
      #1;
      check(e.tag, rdata, e.exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wren  = 1'b1;
    tick(1);
    wren  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wren  = 1'b0;
    addr  = A_SW;
    wdata = '0;
    sw    = 18'h3FFFF;
    btn   = 4'h0;

    tick(3);
    expect_rd("rst_sw", A_SW, 32'h0);
    expect_rd("rst_btn", A_BTN, 32'h0);
    expect_rd("rst_edge", A_EDGE, 32'h0);
    drain();

    rst_n = 1'b1;
    tick(5);
    expect_rd("all_btn_e5", A_BTN, 32'h0);
    drain();
    tick(1);
    expect_rd("all_btn_e6", A_BTN, 32'hF);
    expect_rd("all_edge_e6", A_EDGE, 32'hF);
    expect_rd("sw_ones", A_SW, 32'h3FFFF);
    drain();

    wr(A_EDGE, 32'hF);
    expect_rd("clr_all", A_EDGE, 32'h0);
    drain();
    btn = 4'hF;
    tick(6);
    expect_rd("rel_all_btn", A_BTN, 32'h0);
    expect_rd("rel_all_edge", A_EDGE, 32'h0);
    drain();

    sw = 18'h2A5A5;
    tick(1);
    expect_rd("sw_e1", A_SW, 32'h3FFFF);
    drain();
    tick(1);
    expect_rd("sw_e2", A_SW, 32'h0002A5A5);
    expect_rd("unmapped", A_SWX, 32'h0);
    drain();

    btn[0] = 1'b0;
    tick(3);
    btn[0] = 1'b1;
    tick(1);
    btn[0] = 1'b0;
    tick(3);
    btn[0] = 1'b1;
    tick(6);
    expect_rd("glitch_btn", A_BTN, 32'h0);
    expect_rd("glitch_edge", A_EDGE, 32'h0);
    drain();

    btn[0] = 1'b0;
    tick(5);
    expect_rd("b0_e5", A_BTN, 32'h0);
    drain();
    tick(1);
    expect_rd("b0_e6", A_BTN, 32'h1);
    expect_rd("b0_edge", A_EDGE, 32'h1);
    drain();

    btn[0] = 1'b1;
    tick(5);
    expect_rd("b0_rel_e5", A_BTN, 32'h1);
    drain();
    tick(1);
    expect_rd("b0_rel_btn", A_BTN, 32'h0);
    expect_rd("b0_rel_edge", A_EDGE, 32'h1);
    drain();

    wr(A_BTN, 32'hF);
    expect_rd("wr_btn_ign", A_EDGE, 32'h1);
    drain();
    wr(A_SW, 32'hF);
    expect_rd("wr_sw_ign", A_EDGE, 32'h1);
    expect_rd("wr_sw_sw", A_SW, 32'h0002A5A5);
    drain();
    wr(A_EDGE, 32'h1);
    expect_rd("w1c_b0", A_EDGE, 32'h0);
    drain();

    btn[2] = 1'b0;
    tick(5);
    wr(A_EDGE, 32'h4);
    expect_rd("coll_edge", A_EDGE, 32'h4);
    expect_rd("coll_btn", A_BTN, 32'h4);
    drain();
    wr(A_EDGE, 32'h8);
    expect_rd("w1c_b3_idle", A_EDGE, 32'h4);
    drain();
    wr(A_EDGE, 32'h4);
    expect_rd("w1c_b2", A_EDGE, 32'h0);
    drain();
    btn[2] = 1'b1;
    tick(6);
    expect_rd("b2_rel", A_BTN, 32'h0);
    drain();

    btn[1] = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    expect_rd("mid_rst_btn", A_BTN, 32'h0);
    expect_rd("mid_rst_sw", A_SW, 32'h0);
    drain();
    #1;
    rst_n = 1'b1;
    tick(5);
    expect_rd("b1_rr_e5", A_BTN, 32'h0);
    expect_rd("b1_rr_e5_edge", A_EDGE, 32'h0);
    drain();
    tick(1);
    expect_rd("b1_rr_e6", A_BTN, 32'h2);
    expect_rd("b1_rr_e6_edge", A_EDGE, 32'h2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
